sprite_layer_mixer: RTL and testbench

Parametrised N-layer pixel compositor with per-frame pairwise overlap detection. It sits between the sprite ROM read ports and the colour-palette RAM. Per pixel it picks the winning colour index by fixed layer priority, a ground band and a per-layer flash override. Each frame it latches which layer pairs overlapped and reports this to the Nios II through the game-control import word, with sticky flags that software acknowledges.

---
 rtl/sprite_mix_pkg.sv | 17 +
 rtl/frame_collision_latch.sv | 51 +++++
 rtl/sprite_layer_mixer.sv | 131 +++++++++++++
 tb/tb_sprite_layer_mixer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mix_pkg.sv
// rtl/sprite_mix_pkg.sv - shared constants and pair-numbering helpers for the sprite layer mixer
package sprite_mix_pkg;

  localparam int GROUND_Y_DEF   = 400;
  localparam int GROUND_IDX_DEF = 2;
  localparam int FLASH_IDX_DEF  = 1;

  function automatic int num_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Lexicographic numbering: (0,1)=0, (0,2)=1, ..., (n-2,n-1)=num_pairs(n)-1
  function automatic int pair_index(input int i, input int j, input int n);
    return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
  endfunction

endpackage

// File: rtl/frame_collision_latch.sv
// rtl/frame_collision_latch.sv - per-frame overlap accumulator with frame and sticky flag registers
module frame_collision_latch #(
  parameter int WIDTH = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             vga_vs,
  input  logic [WIDTH-1:0] pix_overlap,
  input  logic             collide_ack,
  output logic [WIDTH-1:0] collide_frame,
  output logic [WIDTH-1:0] collide_sticky,
  output logic             frame_done
);

  logic             vs_prev;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] frame_vec;
  logic             boundary;

  // VS is active low, so the frame ends on its falling edge
  assign boundary  = vs_prev & ~vga_vs;
  assign frame_vec = acc | pix_overlap;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_prev        <= 1'b1;
      acc            <= '0;
      collide_frame  <= '0;
      collide_sticky <= '0;
      frame_done     <= 1'b0;
    end else begin
      vs_prev    <= vga_vs;
      frame_done <= boundary;
      if (boundary) begin
        acc           <= '0;
        collide_frame <= frame_vec;
      end else begin
        acc <= frame_vec;
      end
      // An ack that coincides with a boundary drops old flags but keeps the new frame
      if (boundary && collide_ack) begin
        collide_sticky <= frame_vec;
      end else if (boundary) begin
        collide_sticky <= collide_sticky | frame_vec;
      end else if (collide_ack) begin
        collide_sticky <= '0;
      end
    end
  end

endmodule

// File: rtl/sprite_layer_mixer.sv
// rtl/sprite_layer_mixer.sv - N-layer priority compositor with ground band, flash and pair overlap flags
module sprite_layer_mixer
  import sprite_mix_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int IDX_W        = 4,
  parameter int GROUND_Y     = GROUND_Y_DEF,
  parameter int GROUND_LAYER = 1,
  parameter int GROUND_IDX   = GROUND_IDX_DEF,
  parameter int FLASH_IDX    = FLASH_IDX_DEF,
  localparam int NUM_PAIRS   = num_pairs(NUM_LAYERS)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       layer_flash,
  input  logic [9:0]                  DrawY,
  input  logic                        pix_valid,
  input  logic                        VGA_VS,
  input  logic                        collide_ack,
  output logic [IDX_W-1:0]            color_index,
  output logic [NUM_PAIRS-1:0]        collide_frame,
  output logic [NUM_PAIRS-1:0]        collide_sticky,
  output logic                        frame_done
);

  localparam int         KW           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [9:0] GROUND_Y_V   = 10'(GROUND_Y);
  localparam logic [IDX_W-1:0] GROUND_IDX_V = IDX_W'(GROUND_IDX);
  localparam logic [IDX_W-1:0] FLASH_IDX_V  = IDX_W'(FLASH_IDX);

  logic [NUM_LAYERS*IDX_W-1:0] s1_idx;
  logic [NUM_LAYERS-1:0]       s1_en;
  logic [NUM_LAYERS-1:0]       s1_flash;
  logic [9:0]                  s1_y;
  logic                        s1_valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_idx   <= '0;
      s1_en    <= '0;
      s1_flash <= '0;
      s1_y     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_idx   <= layer_idx;
      s1_en    <= layer_en;
      s1_flash <= layer_flash;
      s1_y     <= DrawY;
      s1_valid <= pix_valid;
    end
  end

  logic [IDX_W-1:0]      idx_arr [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] opaque;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    assign idx_arr[k] = s1_idx[k*IDX_W +: IDX_W];
    assign opaque[k]  = s1_en[k] & (idx_arr[k] != '0);
  end

  logic             win_found;
  logic             win_front;
  logic [KW-1:0]    win_k;
  logic [IDX_W-1:0] win_color;
  logic             in_ground;
  logic [IDX_W-1:0] next_color;

  // Scan from the lowest priority upward so the last hit is the winner
  always_comb begin
    win_found = 1'b0;
    win_front = 1'b0;
    win_k     = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (opaque[k]) begin
        win_found = 1'b1;
        win_front = (k < GROUND_LAYER);
        win_k     = KW'(k);
      end
    end
  end

  assign win_color = s1_flash[win_k] ? FLASH_IDX_V : idx_arr[win_k];
  assign in_ground = (s1_y >= GROUND_Y_V);

  always_comb begin
    next_color = '0;
    if (win_found && win_front) begin
      next_color = win_color;
    end else if (in_ground) begin
      next_color = GROUND_IDX_V;
    end else if (win_found) begin
      next_color = win_color;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      color_index <= '0;
    end else begin
      color_index <= next_color;
    end
  end

  logic [NUM_PAIRS-1:0] pair_hit;
  logic [NUM_PAIRS-1:0] pix_overlap;

  for (genvar i = 0; i < NUM_LAYERS - 1; i++) begin : g_pair_i
    for (genvar j = i + 1; j < NUM_LAYERS; j++) begin : g_pair_j
      assign pair_hit[pair_index(i, j, NUM_LAYERS)] = opaque[i] & opaque[j];
    end
  end

  // Ground band and flash never mask overlap; only the display-area qualifier does
  assign pix_overlap = pair_hit & {NUM_PAIRS{s1_valid}};

  frame_collision_latch #(
    .WIDTH(NUM_PAIRS)
  ) u_latch (
    .Clk           (Clk),
    .Reset         (Reset),
    .vga_vs        (VGA_VS),
    .pix_overlap   (pix_overlap),
    .collide_ack   (collide_ack),
    .collide_frame (collide_frame),
    .collide_sticky(collide_sticky),
    .frame_done    (frame_done)
  );

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// tb/tb_sprite_layer_mixer.sv - directed self-checking bench for sprite_layer_mixer
module tb_sprite_layer_mixer;

  logic        Clk;
  logic        Reset;
  logic [15:0] layer_idx;
  logic [3:0]  layer_en;
  logic [3:0]  layer_flash;
  logic [9:0]  DrawY;
  logic        pix_valid;
  logic        VGA_VS;
  logic        collide_ack;
  logic [3:0]  color_index;
  logic [5:0]  collide_frame;
  logic [5:0]  collide_sticky;
  logic        frame_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  sprite_layer_mixer #(
    .NUM_LAYERS  (4),
    .IDX_W       (4),
    .GROUND_Y    (400),
    .GROUND_LAYER(1),
    .GROUND_IDX  (2),
    .FLASH_IDX   (1)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .layer_idx     (layer_idx),
    .layer_en      (layer_en),
    .layer_flash   (layer_flash),
    .DrawY         (DrawY),
    .pix_valid     (pix_valid),
    .VGA_VS        (VGA_VS),
    .collide_ack   (collide_ack),
    .color_index   (color_index),
    .collide_frame (collide_frame),
    .collide_sticky(collide_sticky),
    .frame_done    (frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // layer_idx packing: {L3, L2, L1, L0}
  task automatic set_px(input logic [15:0] idx, input logic [3:0] en, input logic [3:0] fl,
                        input logic [9:0] y, input logic v);
    layer_idx   = idx;
    layer_en    = en;
    layer_flash = fl;
    DrawY       = y;
    pix_valid   = v;
  endtask

  task automatic clear_px();
    set_px(16'h0000, 4'b0000, 4'b0000, 10'd100, 1'b0);
  endtask

  // Drive VS low for one cycle; returns sampled just after the boundary edge
  task automatic boundary(input logic ack);
    VGA_VS      = 1'b0;
    collide_ack = ack;
    @(negedge Clk);
    VGA_VS      = 1'b1;
    collide_ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    clear_px();
    VGA_VS      = 1'b1;
    collide_ack = 1'b0;
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd0) $display("FAIL reset_color: got %0d want 0", color_index);
    else pass_cnt++;
    total_cnt++;
    if (collide_frame !== 6'b0 || collide_sticky !== 6'b0)
      $display("FAIL reset_collide: got frame=%b sticky=%b want 0/0", collide_frame, collide_sticky);
    else pass_cnt++;
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL reset_no_frame_done: got %b want 0", frame_done);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    set_px({4'd9, 4'd0, 4'd7, 4'd5}, 4'b1111, 4'b0000, 10'd100, 1'b0);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd5) $display("FAIL prio_l0: got %0d want 5", color_index);
    else pass_cnt++;
    set_px({4'd9, 4'd0, 4'd7, 4'd5}, 4'b1110, 4'b0000, 10'd100, 1'b0);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd7) $display("FAIL prio_l1: got %0d want 7", color_index);
    else pass_cnt++;
    set_px({4'd9, 4'd0, 4'd7, 4'd5}, 4'b0000, 4'b0000, 10'd100, 1'b0);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd0) $display("FAIL prio_none: got %0d want 0", color_index);
    else pass_cnt++;
  endtask

  task automatic test_ground();
    set_px({4'd0, 4'd7, 4'd0, 4'd0}, 4'b1111, 4'b0000, 10'd400, 1'b0);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd2) $display("FAIL ground_under: got %0d want 2", color_index);
    else pass_cnt++;
    set_px({4'd0, 4'd7, 4'd0, 4'd3}, 4'b1111, 4'b0000, 10'd400, 1'b0);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd3) $display("FAIL ground_over: got %0d want 3", color_index);
    else pass_cnt++;
    set_px({4'd0, 4'd7, 4'd0, 4'd0}, 4'b1111, 4'b0000, 10'd399, 1'b0);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd7) $display("FAIL ground_above: got %0d want 7", color_index);
    else pass_cnt++;
    set_px({4'd0, 4'd0, 4'd0, 4'd0}, 4'b1111, 4'b0000, 10'd450, 1'b0);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd2) $display("FAIL ground_empty: got %0d want 2", color_index);
    else pass_cnt++;
  endtask

  task automatic test_overlap();
    clear_px();
    repeat (3) @(negedge Clk);
    boundary(1'b1);
    set_px({4'd4, 4'd0, 4'd0, 4'd3}, 4'b1111, 4'b0000, 10'd100, 1'b1);
    @(negedge Clk);
    clear_px();
    repeat (4) @(negedge Clk);
    boundary(1'b0);
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL overlap_frame_done: got %b want 1", frame_done);
    else pass_cnt++;
    total_cnt++;
    if (collide_frame !== 6'b000100) $display("FAIL overlap_frame: got %b want 000100", collide_frame);
    else pass_cnt++;
    total_cnt++;
    if (collide_sticky !== 6'b000100) $display("FAIL overlap_sticky: got %b want 000100", collide_sticky);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL overlap_done_pulse: got %b want 0", frame_done);
    else pass_cnt++;
    repeat (3) @(negedge Clk);
    boundary(1'b0);
    total_cnt++;
    if (collide_frame !== 6'b000000) $display("FAIL overlap_next_frame: got %b want 000000", collide_frame);
    else pass_cnt++;
    total_cnt++;
    if (collide_sticky !== 6'b000100) $display("FAIL overlap_sticky_kept: got %b want 000100", collide_sticky);
    else pass_cnt++;
  endtask

  task automatic test_flash();
    set_px({4'd0, 4'd0, 4'd6, 4'd0}, 4'b1111, 4'b0010, 10'd100, 1'b1);
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd1) $display("FAIL flash_color: got %0d want 1", color_index);
    else pass_cnt++;
    clear_px();
    repeat (3) @(negedge Clk);
    boundary(1'b0);
    total_cnt++;
    if (collide_frame !== 6'b000000) $display("FAIL flash_no_collide: got %b want 000000", collide_frame);
    else pass_cnt++;
  endtask

  task automatic test_pix_valid();
    set_px({4'd0, 4'd0, 4'd2, 4'd3}, 4'b1111, 4'b0000, 10'd100, 1'b0);
    repeat (3) @(negedge Clk);
    clear_px();
    repeat (3) @(negedge Clk);
    boundary(1'b0);
    total_cnt++;
    if (collide_frame !== 6'b000000) $display("FAIL pix_valid_gate: got %b want 000000", collide_frame);
    else pass_cnt++;
  endtask

  task automatic test_ack_boundary();
    set_px({4'd0, 4'd5, 4'd6, 4'd0}, 4'b1111, 4'b0000, 10'd100, 1'b1);
    @(negedge Clk);
    clear_px();
    repeat (3) @(negedge Clk);
    boundary(1'b1);
    total_cnt++;
    if (collide_sticky !== 6'b001000) $display("FAIL ack_boundary_sticky: got %b want 001000", collide_sticky);
    else pass_cnt++;
    total_cnt++;
    if (collide_frame !== 6'b001000) $display("FAIL ack_boundary_frame: got %b want 001000", collide_frame);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Overlap still in stage 1 on the boundary cycle belongs to the ending frame
    set_px({4'd3, 4'd3, 4'd0, 4'd0}, 4'b1111, 4'b0000, 10'd100, 1'b1);
    @(negedge Clk);
    clear_px();
    boundary(1'b0);
    total_cnt++;
    if (collide_frame !== 6'b100000) $display("FAIL edge_same_cycle: got %b want 100000", collide_frame);
    else pass_cnt++;
    total_cnt++;
    if (collide_sticky !== 6'b101000) $display("FAIL edge_sticky_or: got %b want 101000", collide_sticky);
    else pass_cnt++;
    // A pixel presented together with the VS edge lands in the next frame
    repeat (2) @(negedge Clk);
    set_px({4'd0, 4'd4, 4'd0, 4'd4}, 4'b1111, 4'b0000, 10'd100, 1'b1);
    boundary(1'b0);
    clear_px();
    total_cnt++;
    if (collide_frame !== 6'b000000) $display("FAIL edge_pipeline_excl: got %b want 000000", collide_frame);
    else pass_cnt++;
    repeat (3) @(negedge Clk);
    boundary(1'b0);
    total_cnt++;
    if (collide_frame !== 6'b000010) $display("FAIL edge_pipeline_next: got %b want 000010", collide_frame);
    else pass_cnt++;
    total_cnt++;
    if (collide_sticky !== 6'b101010) $display("FAIL edge_sticky_accum: got %b want 101010", collide_sticky);
    else pass_cnt++;
    @(negedge Clk);
    collide_ack = 1'b1;
    @(negedge Clk);
    collide_ack = 1'b0;
    total_cnt++;
    if (collide_sticky !== 6'b000000 || collide_frame !== 6'b000010)
      $display("FAIL ack_only: got sticky=%b frame=%b want 000000/000010", collide_sticky, collide_frame);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    set_px({4'd0, 4'd0, 4'd0, 4'd5}, 4'b0001, 4'b0000, 10'd100, 1'b1);
    @(negedge Clk);
    set_px({4'd0, 4'd0, 4'd7, 4'd5}, 4'b0011, 4'b0000, 10'd100, 1'b1);
    @(negedge Clk);
    set_px({4'd0, 4'd0, 4'd0, 4'd5}, 4'b0001, 4'b0000, 10'd100, 1'b1);
    repeat (3) @(negedge Clk);
    total_cnt++;
    if (color_index !== 4'd5) $display("FAIL rst_mid_pre_color: got %0d want 5", color_index);
    else pass_cnt++;
    #2;
    Reset = 1'b1;
    #1;
    total_cnt++;
    if (color_index !== 4'd0 || collide_frame !== 6'b0 || collide_sticky !== 6'b0 || frame_done !== 1'b0)
      $display("FAIL rst_mid_async: got color=%0d frame=%b sticky=%b done=%b want all 0",
               color_index, collide_frame, collide_sticky, frame_done);
    else pass_cnt++;
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      total_cnt++;
      if (frame_done !== 1'b0) $display("FAIL rst_mid_no_done: cycle %0d got %b want 0", c, frame_done);
      else pass_cnt++;
    end
    boundary(1'b0);
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL rst_mid_first_done: got %b want 1", frame_done);
    else pass_cnt++;
    total_cnt++;
    if (collide_frame !== 6'b000000) $display("FAIL rst_mid_frame: got %b want 000000", collide_frame);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_ground();
    test_overlap();
    test_flash();
    test_pix_valid();
    test_ack_boundary();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
